cache_line_fill_unit: RTL and testbench
=======================================

# cache_line_fill_unit

Miss-handling stage directly downstream of `cache_controller`. It accepts one line request per miss, optionally writes back the dirty victim line first, then fetches the requested line beat by beat over a narrow memory bus. It assembles the full line and returns it to the controller with a one-cycle response pulse, which feeds `i_memory_line` / `i_memory_response`.

## Interface
Parameters:
- `LINE_SIZE_BYTES`, 64: cache line size in bytes; `LINE_SIZE_BITS` = 8*`LINE_SIZE_BYTES`.
- `ADDRESS_WIDTH`, 32: byte address width.
- `OFFSET_BITS`, 6: log2(`LINE_SIZE_BYTES`).
- `MEM_DATA_WIDTH`, 32: memory beat width in bits.
  - Must be a power of two, ≥8, and divide `LINE_SIZE_BITS`.
  - `BEATS` = `LINE_SIZE_BITS`/`MEM_DATA_WIDTH` (default 16).

Ports:
- `clk`  in  1  clock, all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_miss_valid`  in  1  controller requests a line fill.
- `o_miss_ready`  out  1  high only in IDLE; request accepted when valid&&ready.
- `i_miss_addr`  in  `ADDRESS_WIDTH`  address of missing line; offset bits ignored.
- `i_wb_valid`  in  1  victim is valid and dirty; sampled with the request.
- `i_wb_addr`  in  `ADDRESS_WIDTH`  victim line address; offset bits ignored.
- `i_wb_line`  in  `LINE_SIZE_BITS`  victim line data, sampled at accept.
- `o_fill_valid`  out  1  one-cycle pulse: `o_fill_line` holds the fetched line.
- `o_fill_line`  out  `LINE_SIZE_BITS`  assembled line; holds until overwritten by the next fill.
- `o_busy`  out  1  high in every state except IDLE.
- `o_mem_req`  out  1  memory beat request.
- `o_mem_we`  out  1  1 = write beat, 0 = read beat.
- `o_mem_addr`  out  `ADDRESS_WIDTH`  byte address of the current beat.
- `o_mem_wdata`  out  `MEM_DATA_WIDTH`  write beat data.
- `i_mem_ack`  in  1  beat complete; read data valid in the same cycle.
- `i_mem_rdata`  in  `MEM_DATA_WIDTH`  read beat data.

## Operation
- FSM states: IDLE, WB, FILL, RESP.
- IDLE:
  - On accept, latch the line-aligned miss address, victim address, `i_wb_line` and `i_wb_valid`.
  - Clear the beat counter.
  - Next state is WB if `i_wb_valid`, else FILL.
- WB:
  - `o_mem_req`=1, `o_mem_we`=1.
  - `o_mem_wdata` = victim line bits [k*`MEM_DATA_WIDTH` +: `MEM_DATA_WIDTH`] for beat k.
  - On ack at k=`BEATS`-1: clear counter, go to FILL.
- FILL:
  - `o_mem_req`=1, `o_mem_we`=0.
  - On ack, write `i_mem_rdata` into line bits [k*`MEM_DATA_WIDTH` +: `MEM_DATA_WIDTH`], so beat 0 lands in the LSBs.
  - On ack at the last beat, go to RESP.
- RESP:
  - `o_fill_valid`=1 for exactly this cycle, then IDLE.
  - `o_fill_line` is updated only by beat writes during FILL.
- Beat address: {line_addr[`ADDRESS_WIDTH`-1:`OFFSET_BITS`], k, zeros(log2(`MEM_DATA_WIDTH`/8))}. No carry ever reaches the tag or index bits.
- Beat counter: `$clog2(BEATS)` bits. It wraps to 0 only via the explicit clear, never by overflow.
- Bus handshake:
  - `o_mem_addr`, `o_mem_we` and `o_mem_wdata` are stable while `o_mem_req`=1 and no ack has occurred.
  - `o_mem_req` stays high across consecutive beats.
  - The request deasserts in the cycle after the final ack.
  - `i_mem_ack` while `o_mem_req`=0 is ignored.
- `i_miss_valid` while busy is ignored; `o_miss_ready`=0.
- A victim address equal to the miss address is legal: write-back completes before any read beat is issued.

## Timing
- Reset values: `o_miss_ready`=1, `o_busy`=0, `o_fill_valid`=0, `o_fill_line`=0, `o_mem_req`=0, `o_mem_we`=0, `o_mem_addr`=0, `o_mem_wdata`=0. FSM=IDLE, counter=0.
- Reset mid-transfer: the FSM aborts immediately (asynchronous) and `o_mem_req` drops in the same cycle. No `o_fill_valid` is issued for the aborted request.
- With ack every cycle, request accepted at edge T:
  - First beat request is visible in cycle T+1.
  - Fill only: beats are acked in T+1..T+`BEATS`; `o_fill_valid` is high in cycle T+`BEATS`+1.
  - With write-back: add `BEATS` cycles.
- `o_miss_ready` rises in the cycle after RESP, so back-to-back misses have a 1-cycle minimum gap after the pulse.
- Ack stalls of N cycles per beat extend latency by N per beat. Outputs hold throughout the stall.

## Test plan
- Reset, then a clean miss at 0x0000_1234 with a memory model returning 0xA000_0000+k and always acking → read addresses 0x1200, 0x1204 … 0x123C. `o_fill_valid` pulses once at accept+17; `o_fill_line`[31:0]=0xA000_0000 and [511:480]=0xA000_000F.
- Dirty victim 0x0000_8040 with line bytes 0x00..0x3F, then miss at 0x1200 → 16 writes to 0x8040..0x807C with wdata[0]=0x03020100, then 16 reads. Fill pulse at accept+33.
- Random 0–3 cycle ack stalls → `o_mem_addr`/`o_mem_wdata` stable during each stall, line contents identical to the no-stall run, no extra or missing beats.
- `i_miss_valid` held high during a fill → `o_miss_ready`=0 throughout. Exactly one fill pulse per accepted request; second request accepted the cycle after RESP.
- `rst` asserted at beat 7 of FILL → `o_mem_req`=0 immediately, no `o_fill_valid`. A subsequent miss completes normally with all 16 beats.
- Spurious `i_mem_ack` in IDLE → no state change, counter remains 0.

Source files
------------

// File: rtl/cache_line_fill_unit_if.sv
// Bundle of the controller-side miss handshake and the narrow memory beat bus
// of the cache line fill unit. The fill unit uses the slave view; the
// controller / memory environment uses the master view.
interface cache_line_fill_unit_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int LINE_SIZE_BITS = 512,
  parameter int MEM_DATA_WIDTH = 32
);
  // controller -> fill unit
  logic                      i_miss_valid;
  logic [ADDRESS_WIDTH-1:0]  i_miss_addr;
  logic                      i_wb_valid;
  logic [ADDRESS_WIDTH-1:0]  i_wb_addr;
  logic [LINE_SIZE_BITS-1:0] i_wb_line;
  // fill unit -> controller
  logic                      o_miss_ready;
  logic                      o_fill_valid;
  logic [LINE_SIZE_BITS-1:0] o_fill_line;
  logic                      o_busy;
  // fill unit -> memory
  logic                      o_mem_req;
  logic                      o_mem_we;
  logic [ADDRESS_WIDTH-1:0]  o_mem_addr;
  logic [MEM_DATA_WIDTH-1:0] o_mem_wdata;
  // memory -> fill unit
  logic                      i_mem_ack;
  logic [MEM_DATA_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_miss_valid, i_miss_addr, i_wb_valid, i_wb_addr, i_wb_line,
    input  i_mem_ack, i_mem_rdata,
    output o_miss_ready, o_fill_valid, o_fill_line, o_busy,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_miss_valid, i_miss_addr, i_wb_valid, i_wb_addr, i_wb_line,
    output i_mem_ack, i_mem_rdata,
    input  o_miss_ready, o_fill_valid, o_fill_line, o_busy,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/cache_line_fill_unit.sv
// Cache miss handler: optionally writes back a dirty victim line, then reads
// the missing line beat by beat over a narrow memory bus, assembles it and
// returns it to the controller with a one-cycle fill pulse.
module cache_line_fill_unit #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int MEM_DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_line_fill_unit_if.slave  bus
);
  localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES;
  localparam int BEATS          = LINE_SIZE_BITS / MEM_DATA_WIDTH;
  localparam int CNT_W          = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SH        = $clog2(MEM_DATA_WIDTH / 8);
  localparam int TAG_W          = ADDRESS_WIDTH - OFFSET_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]                r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [TAG_W-1:0]          r_miss_tag;
  logic [TAG_W-1:0]          r_wb_tag;
  logic [LINE_SIZE_BITS-1:0] r_wb_line;
  logic [LINE_SIZE_BITS-1:0] r_fill_line;

  logic                      w_accept;
  logic                      w_req;
  logic                      w_ack;
  logic                      w_last;
  logic [OFFSET_BITS-1:0]    w_off;
  logic                      w_unused_bits;

  assign w_accept = (r_state == S_IDLE) && bus.i_miss_valid;
  assign w_req    = (r_state == S_WB) || (r_state == S_FILL);
  // Acks outside a beat request are meaningless and must not move the FSM.
  assign w_ack    = w_req && bus.i_mem_ack;
  assign w_last   = (r_cnt == CNT_W'(BEATS - 1));
  // Beat offset inside the line; the counter never overflows into the tag.
  assign w_off    = OFFSET_BITS'(r_cnt) << BYTE_SH;
  // Offset bits of incoming addresses are deliberately ignored.
  assign w_unused_bits = ^{bus.i_miss_addr[OFFSET_BITS-1:0], bus.i_wb_addr[OFFSET_BITS-1:0]};

  // Control FSM and beat counter; asynchronous reset aborts any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_state <= bus.i_wb_valid ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (w_ack) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_FILL;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_ack) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_RESP;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Capture the request at accept: line tags and the victim data to write back.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_miss_tag <= bus.i_miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS];
      r_wb_tag   <= bus.i_wb_addr[ADDRESS_WIDTH-1:OFFSET_BITS];
      r_wb_line  <= bus.i_wb_line;
    end
  end

  // Assemble the fetched line; beat 0 lands in the least significant bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_line <= '0;
    end else if ((r_state == S_FILL) && w_ack) begin
      r_fill_line[int'(r_cnt)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= bus.i_mem_rdata;
    end
  end

  // Bus outputs are decoded from state so they drop together with the FSM on reset.
  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (r_state == S_WB) begin
      bus.o_mem_addr  = {r_wb_tag, w_off};
      bus.o_mem_wdata = r_wb_line[int'(r_cnt)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end else if (r_state == S_FILL) begin
      bus.o_mem_addr  = {r_miss_tag, w_off};
    end
  end

  assign bus.o_mem_req    = w_req;
  assign bus.o_mem_we     = (r_state == S_WB);
  assign bus.o_miss_ready = (r_state == S_IDLE);
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_fill_valid = (r_state == S_RESP);
  assign bus.o_fill_line  = r_fill_line;
endmodule

// File: tb/tb_cache_line_fill_unit.sv
// Directed bench for cache_line_fill_unit: a memory model that acks beats
// (optionally after random stalls) and returns 0xA000_0000+k on read beat k.
module tb_cache_line_fill_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_line_fill_unit_if #(.ADDRESS_WIDTH(32), .LINE_SIZE_BITS(512), .MEM_DATA_WIDTH(32)) bus ();

  cache_line_fill_unit #(
    .LINE_SIZE_BYTES(64), .ADDRESS_WIDTH(32), .OFFSET_BITS(6), .MEM_DATA_WIDTH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]  wr_addr [16];
  logic [31:0]  wr_data [16];
  logic [31:0]  rd_addr [16];
  int           n_wr, n_rd, n_pulse, pulse_cyc, last_wr_cyc, first_rd_cyc, ready_bad;
  logic [511:0] exp_line;
  logic [511:0] victim_line;

  // One miss transaction with the memory model; abort_rd >= 0 asserts reset
  // while read beat abort_rd is being requested.
  task automatic do_miss(input logic [31:0] maddr, input logic wbv, input logic [31:0] waddr,
                         input logic [511:0] wline, input int stall_max, input bit hold,
                         input int abort_rd);
    logic [31:0] cur_addr, cur_wd;
    logic        cur_we;
    bit          beat_new, done;
    int          stall_left, c;
    n_wr = 0; n_rd = 0; n_pulse = 0; pulse_cyc = -1;
    last_wr_cyc = -1; first_rd_cyc = -1; ready_bad = 0;
    cur_addr = '0; cur_wd = '0; cur_we = 1'b0; stall_left = 0;
    bus.i_miss_valid = 1'b1;
    bus.i_miss_addr  = maddr;
    bus.i_wb_valid   = wbv;
    bus.i_wb_addr    = waddr;
    bus.i_wb_line    = wline;
    bus.i_mem_ack    = 1'b0;
    n_assert++;
    if (bus.o_miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready: got %b want 1", bus.o_miss_ready);
    end
    @(posedge clk);
    beat_new = 1'b1; done = 1'b0; c = 0;
    while (!done) begin
      @(negedge clk);
      c++;
      if (!hold) bus.i_miss_valid = 1'b0;
      bus.i_mem_ack = 1'b0;
      if (hold && pulse_cyc < 0 && bus.o_miss_ready !== 1'b0) ready_bad++;
      if (bus.o_fill_valid === 1'b1) begin
        n_pulse++;
        if (pulse_cyc < 0) pulse_cyc = c;
      end
      if (abort_rd >= 0 && n_rd == abort_rd && beat_new && bus.o_mem_req === 1'b1 && bus.o_mem_we === 1'b0) begin
        rst = 1'b1;
        #1;
        n_assert++;
        if ({bus.o_mem_req, bus.o_busy, bus.o_miss_ready} !== 3'b001) begin
          n_fail++; $display("FAIL abort_outputs: req/busy/ready got %b want 001", {bus.o_mem_req, bus.o_busy, bus.o_miss_ready});
        end
        n_assert++;
        if (bus.o_fill_line !== 512'd0) begin
          n_fail++; $display("FAIL abort_line: got %h want 0", bus.o_fill_line[31:0]);
        end
        repeat (2) begin
          @(negedge clk);
          if (bus.o_fill_valid === 1'b1) n_pulse++;
        end
        rst = 1'b0;
        return;
      end
      if (bus.o_mem_req === 1'b1) begin
        if (beat_new) begin
          cur_addr = bus.o_mem_addr; cur_wd = bus.o_mem_wdata; cur_we = bus.o_mem_we;
          stall_left = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
          beat_new = 1'b0;
        end else begin
          n_assert++;
          if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !== {cur_we, cur_addr, cur_wd}) begin
            n_fail++; $display("FAIL stall_stable: got %b/%h/%h want %b/%h/%h", bus.o_mem_we,
                               bus.o_mem_addr, bus.o_mem_wdata, cur_we, cur_addr, cur_wd);
          end
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.i_mem_ack = 1'b1;
          beat_new = 1'b1;
          if (cur_we) begin
            if (n_wr < 16) begin wr_addr[n_wr] = cur_addr; wr_data[n_wr] = cur_wd; end
            n_wr++; last_wr_cyc = c;
          end else begin
            if (n_rd < 16) rd_addr[n_rd] = cur_addr;
            bus.i_mem_rdata = 32'hA000_0000 + 32'(n_rd);
            if (n_rd == 0) first_rd_cyc = c;
            n_rd++;
          end
        end
      end
      if (pulse_cyc >= 0 && c == pulse_cyc + 1) begin
        done = 1'b1;
        n_assert++;
        if (bus.o_miss_ready !== 1'b1 || bus.o_fill_valid !== 1'b0) begin
          n_fail++; $display("FAIL post_resp: ready/fill_valid got %b%b want 10", bus.o_miss_ready, bus.o_fill_valid);
        end
      end else if (c > 300) begin
        done = 1'b1;
        n_assert++; n_fail++;
        $display("FAIL timeout: no fill pulse after %0d cycles, want one", c);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_miss_valid = 1'b0; bus.i_miss_addr = '0; bus.i_wb_valid = 1'b0;
    bus.i_wb_addr = '0; bus.i_wb_line = '0; bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({bus.o_miss_ready, bus.o_busy, bus.o_fill_valid, bus.o_mem_req, bus.o_mem_we} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: ready/busy/fv/req/we got %b want 10000",
                         {bus.o_miss_ready, bus.o_busy, bus.o_fill_valid, bus.o_mem_req, bus.o_mem_we});
    end
    n_assert++;
    if ({bus.o_mem_addr, bus.o_mem_wdata} !== 64'd0 || bus.o_fill_line !== 512'd0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h line0 %h want zeros", bus.o_mem_addr,
                         bus.o_mem_wdata, bus.o_fill_line[31:0]);
    end
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({bus.o_miss_ready, bus.o_busy} !== 2'b10) begin
      n_fail++; $display("FAIL after_reset: ready/busy got %b want 10", {bus.o_miss_ready, bus.o_busy});
    end
  endtask

  task automatic test_fill_only();
    int bad;
    do_miss(32'h0000_1234, 1'b0, 32'h0, 512'd0, 0, 1'b0, -1);
    n_assert++;
    if (n_rd != 16 || n_wr != 0) begin
      n_fail++; $display("FAIL fill_beats: reads %0d writes %0d want 16 0", n_rd, n_wr);
    end
    n_assert++;
    if (pulse_cyc != 17 || n_pulse != 1) begin
      n_fail++; $display("FAIL fill_pulse: cycle %0d count %0d want 17 1", pulse_cyc, n_pulse);
    end
    bad = 0;
    for (int k = 0; k < 16; k++) if (rd_addr[k] !== 32'h1200 + 32'(4*k)) bad++;
    n_assert++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fill_addr: %0d wrong addresses, first %h want 00001200", bad, rd_addr[0]);
    end
    n_assert++;
    if (bus.o_fill_line[31:0] !== 32'hA000_0000 || bus.o_fill_line[511:480] !== 32'hA000_000F) begin
      n_fail++; $display("FAIL fill_ends: got %h/%h want a0000000/a000000f", bus.o_fill_line[31:0], bus.o_fill_line[511:480]);
    end
    n_assert++;
    if (bus.o_fill_line !== exp_line) begin
      n_fail++; $display("FAIL fill_line: word7 got %h want %h", bus.o_fill_line[255:224], exp_line[255:224]);
    end
  endtask

  task automatic test_writeback(input int stall_max, input string tag);
    int bad_a, bad_d;
    do_miss(32'h0000_1200, 1'b1, 32'h0000_8040, victim_line, stall_max, 1'b0, -1);
    n_assert++;
    if (n_wr != 16 || n_rd != 16 || n_pulse != 1) begin
      n_fail++; $display("FAIL %s_beats: writes %0d reads %0d pulses %0d want 16 16 1", tag, n_wr, n_rd, n_pulse);
    end
    n_assert++;
    if (wr_data[0] !== 32'h0302_0100) begin
      n_fail++; $display("FAIL %s_wdata0: got %h want 03020100", tag, wr_data[0]);
    end
    bad_a = 0; bad_d = 0;
    for (int k = 0; k < 16; k++) begin
      if (wr_addr[k] !== 32'h8040 + 32'(4*k)) bad_a++;
      if (wr_data[k] !== victim_line[32*k +: 32]) bad_d++;
      if (rd_addr[k] !== 32'h1200 + 32'(4*k)) bad_a++;
    end
    n_assert++;
    if (bad_a != 0 || bad_d != 0) begin
      n_fail++; $display("FAIL %s_beat_contents: %0d bad addresses %0d bad data want 0 0", tag, bad_a, bad_d);
    end
    n_assert++;
    if (!(last_wr_cyc < first_rd_cyc)) begin
      n_fail++; $display("FAIL %s_order: last write cycle %0d first read cycle %0d want write first", tag, last_wr_cyc, first_rd_cyc);
    end
    n_assert++;
    if ((stall_max == 0 && pulse_cyc != 33) || (stall_max != 0 && pulse_cyc < 33)) begin
      n_fail++; $display("FAIL %s_latency: pulse cycle %0d want %s33", tag, pulse_cyc, (stall_max == 0) ? "" : ">=");
    end
    n_assert++;
    if (bus.o_fill_line !== exp_line) begin
      n_fail++; $display("FAIL %s_line: word15 got %h want %h", tag, bus.o_fill_line[511:480], exp_line[511:480]);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_miss(32'h0000_1234, 1'b0, 32'h0, 512'd0, 0, 1'b1, -1);
    n_assert++;
    if (ready_bad != 0 || n_pulse != 1) begin
      n_fail++; $display("FAIL b2b_first: ready-high cycles %0d pulses %0d want 0 1", ready_bad, n_pulse);
    end
    do_miss(32'h0000_5678, 1'b0, 32'h0, 512'd0, 0, 1'b0, -1);
    bad = 0;
    for (int k = 0; k < 16; k++) if (rd_addr[k] !== 32'h5640 + 32'(4*k)) bad++;
    n_assert++;
    if (bad != 0 || n_rd != 16 || pulse_cyc != 17 || n_pulse != 1) begin
      n_fail++; $display("FAIL b2b_second: bad addr %0d reads %0d pulse %0d count %0d want 0 16 17 1", bad, n_rd, pulse_cyc, n_pulse);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_miss(32'h0000_1234, 1'b0, 32'h0, 512'd0, 0, 1'b0, 7);
    n_assert++;
    if (n_pulse != 0 || n_rd != 7) begin
      n_fail++; $display("FAIL abort_pulse: pulses %0d reads %0d want 0 7", n_pulse, n_rd);
    end
    do_miss(32'h0000_2000, 1'b0, 32'h0, 512'd0, 0, 1'b0, -1);
    n_assert++;
    if (n_rd != 16 || pulse_cyc != 17 || rd_addr[0] !== 32'h2000 || bus.o_fill_line !== exp_line) begin
      n_fail++; $display("FAIL after_abort: reads %0d pulse %0d addr0 %h want 16 17 00002000", n_rd, pulse_cyc, rd_addr[0]);
    end
  endtask

  task automatic test_spurious_ack();
    int bad;
    bad = 0;
    repeat (3) begin
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      if ({bus.o_miss_ready, bus.o_busy, bus.o_mem_req} !== 3'b100) bad++;
    end
    bus.i_mem_ack = 1'b0;
    n_assert++;
    if (bad != 0) begin
      n_fail++; $display("FAIL spurious_idle: %0d cycles left IDLE want 0", bad);
    end
    do_miss(32'h0000_1234, 1'b0, 32'h0, 512'd0, 0, 1'b0, -1);
    n_assert++;
    if (rd_addr[0] !== 32'h1200 || n_rd != 16 || bus.o_fill_line !== exp_line) begin
      n_fail++; $display("FAIL spurious_counter: addr0 %h reads %0d want 00001200 16", rd_addr[0], n_rd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = 32'hA000_0000 + 32'(k);
    for (int i = 0; i < 64; i++) victim_line[8*i +: 8] = 8'(i);
    test_reset();
    test_fill_only();
    test_writeback(0, "wb");
    test_writeback(3, "stall");
    test_back_to_back();
    test_reset_mid_fill();
    test_spurious_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
